// File: rtl/bus_arbiter4_if.sv
// Shared-bus arbiter interface.
// Bundles the request lines, the four candidate data words and the arbiter's
// grant/select/bus outputs so both sides can be wired with one connection.
//   master modport : the arbiter, which owns the grant and drives the shared bus.
//   slave  modport : the requesting units, which raise requests, supply data and
//                    observe the grant and bus.
interface bus_arbiter4_if #(
  parameter int unsigned TAM = 16
);
  logic [3:0]     ARB_req;
  logic [TAM-1:0] ARB_in0;
  logic [TAM-1:0] ARB_in1;
  logic [TAM-1:0] ARB_in2;
  logic [TAM-1:0] ARB_in3;
  logic [3:0]     ARB_gnt;
  logic [3:0]     ARB_sel;
  logic           ARB_busy;
  logic [TAM-1:0] ARB_out;
  logic           ARB_valid;

  modport master (
    input  ARB_req,
    input  ARB_in0,
    input  ARB_in1,
    input  ARB_in2,
    input  ARB_in3,
    output ARB_gnt,
    output ARB_sel,
    output ARB_busy,
    output ARB_out,
    output ARB_valid
  );

  modport slave (
    output ARB_req,
    output ARB_in0,
    output ARB_in1,
    output ARB_in2,
    output ARB_in3,
    input  ARB_gnt,
    input  ARB_sel,
    input  ARB_busy,
    input  ARB_out,
    input  ARB_valid
  );
endinterface

// File: rtl/bus_arbiter4.sv
// Four-way round-robin arbiter and sequencer for a shared TAM-bit bus.
// Picks one requester, drives a registered one-hot grant and mux select, and
// registers the selected master's word onto the shared bus one cycle later.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - bus_arbiter4_if.master:
//            ARB_req[3:0]  request lines, bit i = master i
//            ARB_in0..3    data words from masters 0..3
//            ARB_gnt[3:0]  one-hot grant (registered)
//            ARB_sel[3:0]  {2'b00, granted index} (registered)
//            ARB_busy      a grant is active
//            ARB_out       registered bus data
//            ARB_valid     ARB_out carries data from a granted master
module bus_arbiter4 #(
  parameter int unsigned TAM      = 16,
  parameter int unsigned HOLD_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter4_if.master bus
);

  // Last cycle a contended owner may keep the grant before it must hand over.
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [3:0]     sel_q, sel_d;
  logic           busy_q, busy_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [1:0]     last_q, last_d;
  logic [TAM-1:0] out_q, out_d;
  logic           valid_q, valid_d;

  logic [3:0]     others;
  logic           own_req;
  logic [1:0]     pick_all;
  logic [1:0]     pick_oth;
  logic [TAM-1:0] mux_data;

  // Round-robin search: first asserted request starting just after 'last'
  // and wrapping through all four indices.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // In GRANT the owner is the one-hot grant itself, so masking by gnt_q
  // separates the owner's request from everyone else's.
  assign own_req  = |(bus.ARB_req & gnt_q);
  assign others   = bus.ARB_req & ~gnt_q;
  assign pick_all = rr_pick(bus.ARB_req, last_q);
  assign pick_oth = rr_pick(others, last_q);

  // Bus mux driven by the registered select, so ARB_out trails ARB_gnt by one cycle.
  always_comb begin
    mux_data = bus.ARB_in0;
    unique case (sel_q[1:0])
      2'd0:    mux_data = bus.ARB_in0;
      2'd1:    mux_data = bus.ARB_in1;
      2'd2:    mux_data = bus.ARB_in2;
      2'd3:    mux_data = bus.ARB_in3;
      default: mux_data = bus.ARB_in0;
    endcase
  end

  // Next-state and grant decision.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: begin
        if (bus.ARB_req != 4'b0000) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << pick_all;
          sel_d   = {2'b00, pick_all};
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          last_d  = pick_all;
        end
      end

      StGrant: begin
        if (own_req) begin
          if (others == 4'b0000) begin
            // Uncontended ownership never times out.
            cnt_d = 8'd0;
          end else if (cnt_q == HoldLast) begin
            gnt_d  = 4'b0001 << pick_oth;
            sel_d  = {2'b00, pick_oth};
            cnt_d  = 8'd0;
            last_d = pick_oth;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (others != 4'b0000) begin
          // Direct handover without an idle bubble.
          gnt_d  = 4'b0001 << pick_oth;
          sel_d  = {2'b00, pick_oth};
          cnt_d  = 8'd0;
          last_d = pick_oth;
        end else begin
          // Release; ARB_sel keeps its last value.
          state_d = StIdle;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Data path: capture only while a grant is active, otherwise hold.
  always_comb begin
    out_d   = busy_q ? mux_data : out_q;
    valid_d = busy_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 4'b0000;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
      last_q  <= 2'd3;  // master 0 first after reset
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ARB_gnt   = gnt_q;
  assign bus.ARB_sel   = sel_q;
  assign bus.ARB_busy  = busy_q;
  assign bus.ARB_out   = out_q;
  assign bus.ARB_valid = valid_q;

endmodule
